// File: rtl/raster_coord_gen.sv
// Raster coordinate generator: walks x/y over a WIDTH x HEIGHT frame in PPC-pixel beats
// with valid/ready handshaking, single-shot or continuous frames, and a sticky stop request.
module raster_coord_gen #(
  parameter int WIDTH   = 1080,
  parameter int HEIGHT  = 960,
  parameter int PPC     = 1,
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_single,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic [15:0]        frame_cnt,
  output logic               busy,
  output logic               done
);

  if (!(PPC == 1 || PPC == 2 || PPC == 4)) begin : g_bad_ppc
    $error("raster_coord_gen: PPC must be 1, 2 or 4");
  end
  if ((WIDTH % PPC) != 0) begin : g_bad_width
    $error("raster_coord_gen: WIDTH must be a multiple of PPC");
  end
  if (((WIDTH >> COORD_W) != 0) || ((HEIGHT >> COORD_W) != 0)) begin : g_bad_coord_w
    $error("raster_coord_gen: COORD_W too small for WIDTH/HEIGHT");
  end

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - PPC);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_STEP = COORD_W'(PPC);
  localparam logic [COORD_W-1:0] Y_STEP = COORD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         rst_sync_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic               stop_r;
  logic [15:0]        frame_cnt_r;
  logic               xfer_s;
  logic               eol_s;
  logic               eof_s;
  logic               end_s;

  assign eol_s  = (x_r == X_LAST);
  assign eof_s  = eol_s && (y_r == Y_LAST);
  assign xfer_s = (state_r == ST_RUN) && out_ready;
  // A stop arriving on the very eof beat still ends this frame.
  assign end_s  = mode_single || stop_r || stop;

  // Reset release synchroniser; start is only honoured once both stages are set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && rst_sync_r[1]) state_s = ST_RUN;
        else                        state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (xfer_s && eof_s && end_s) state_s = ST_DONE;
        else                          state_s = ST_RUN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, coordinates, sticky stop and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      y_r         <= '0;
      stop_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_RUN) stop_r <= stop_r | stop;
      else                   stop_r <= 1'b0;
      if (xfer_s) begin
        if (eol_s) begin
          x_r <= '0;
          y_r <= eof_s ? '0 : (y_r + Y_STEP);
        end else begin
          x_r <= x_r + X_STEP;
          y_r <= y_r;
        end
        if (eof_s) frame_cnt_r <= frame_cnt_r + 16'd1;
        else       frame_cnt_r <= frame_cnt_r;
      end else if (state_r != ST_RUN) begin
        x_r <= '0;
        y_r <= '0;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
    end
  end

  assign out_valid = (state_r == ST_RUN);
  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);
  assign out_x     = x_r;
  assign out_y     = y_r;
  assign out_sof   = out_valid && (x_r == '0) && (y_r == '0);
  assign out_eol   = out_valid && eol_s;
  assign out_eof   = out_valid && eof_s;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_raster_coord_gen.sv
// Scoreboard bench for raster_coord_gen: an 8x4 PPC=1 instance and a 16x2 PPC=4 instance.
module tb_raster_coord_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_start, a_stop, a_mode, a_ready, a_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic [11:0] a_x, a_y;
  logic [15:0] a_frame;
  logic        b_start, b_stop, b_mode, b_ready, b_valid, b_sof, b_eol, b_eof, b_busy, b_done;
  logic [11:0] b_x, b_y;
  logic [15:0] b_frame;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          a_eof_cyc = -10;
  int          a_done_cnt = 0;
  int          b_done_cnt = 0;
  bit          rand_rdy = 1'b0;

  always #5 clk = ~clk;

  raster_coord_gen #(.WIDTH(8), .HEIGHT(4), .PPC(1), .COORD_W(12)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .mode_single(a_mode),
    .out_valid(a_valid), .out_ready(a_ready), .out_x(a_x), .out_y(a_y),
    .out_sof(a_sof), .out_eol(a_eol), .out_eof(a_eof), .frame_cnt(a_frame),
    .busy(a_busy), .done(a_done)
  );

  raster_coord_gen #(.WIDTH(16), .HEIGHT(2), .PPC(4), .COORD_W(12)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .mode_single(b_mode),
    .out_valid(b_valid), .out_ready(b_ready), .out_x(b_x), .out_y(b_y),
    .out_sof(b_sof), .out_eol(b_eol), .out_eof(b_eof), .frame_cnt(b_frame),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected beat word: {pad, x, y, sof, eol, eof}.
  task automatic push_frame(input bit to_b, input int w, input int h, input int ppc);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x += ppc) begin
        logic [31:0] e;
        e = {5'd0, 12'(x), 12'(y), (x == 0 && y == 0), (x == w - ppc),
             (x == w - ppc && y == h - 1)};
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    chk("a_latency_valid", {31'd0, a_valid}, 32'd1);
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((a_busy || a_valid || a_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("a_timeout", 32'd1, 32'd0);
    chk("a_queue_empty", qa.size(), 32'd0);
  endtask

  // Ready driver: always ready, or a coin flip each cycle when rand_rdy is set.
  initial begin
    a_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboards: every accepted beat must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (a_valid && a_ready) begin
      if (qa.size() == 0) chk("a_extra_beat", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_beat", {5'd0, a_x, a_y, a_sof, a_eol, a_eof}, e);
      end
      if (a_eof) a_eof_cyc = cyc;
    end
    if (a_done) begin
      a_done_cnt++;
      chk("a_done_after_eof", cyc - a_eof_cyc, 32'd1);
    end
    if (b_valid && b_ready) begin
      if (qb.size() == 0) chk("b_extra_beat", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_beat", {5'd0, b_x, b_y, b_sof, b_eol, b_eof}, e);
      end
    end
    if (b_done) b_done_cnt++;
  end

  initial begin
    reset = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_mode = 1'b1;
    b_start = 1'b0; b_stop = 1'b0; b_mode = 1'b1; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_busy_done", {30'd0, a_busy, a_done}, 32'd0);
    chk("rst_flags", {29'd0, a_sof, a_eol, a_eof}, 32'd0);
    chk("rst_frame_cnt", {16'd0, a_frame}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    // Single frame, always ready.
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    wait_idle_a(200);
    chk("single_frame_cnt", {16'd0, a_frame}, 32'd1);
    chk("single_done_cnt", a_done_cnt, 32'd1);

    // Single frame with random backpressure.
    rand_rdy = 1'b1;
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    wait_idle_a(1000);
    rand_rdy = 1'b0;
    chk("stall_frame_cnt", {16'd0, a_frame}, 32'd2);

    // Continuous mode, stop early in frame 0.
    a_mode = 1'b0;
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    repeat (4) @(posedge clk);
    #1 a_stop = 1'b1;
    @(posedge clk); #1 a_stop = 1'b0;
    wait_idle_a(200);
    chk("stop_mid_frame_cnt", {16'd0, a_frame}, 32'd3);
    chk("stop_mid_done_cnt", a_done_cnt, 32'd3);

    // Continuous mode, stop coincident with the eof transfer.
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    repeat (31) @(posedge clk);
    #1 a_stop = 1'b1;
    @(posedge clk); #1 a_stop = 1'b0;
    wait_idle_a(200);
    chk("stop_eof_frame_cnt", {16'd0, a_frame}, 32'd4);

    // Start during RUN must not restart the frame.
    a_mode = 1'b1;
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    repeat (10) @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_idle_a(200);
    chk("restart_frame_cnt", {16'd0, a_frame}, 32'd5);
    chk("restart_done_cnt", a_done_cnt, 32'd5);

    // Asynchronous reset mid-frame.
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, a_valid}, 32'd0);
    chk("async_rst_frame_cnt", {16'd0, a_frame}, 32'd0);
    chk("async_rst_busy", {31'd0, a_busy}, 32'd0);
    qa.delete();
    @(posedge clk); #1 reset = 1'b1; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    chk("start_at_release_ignored", {31'd0, a_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("no_beat_after_reset", {31'd0, a_valid}, 32'd0);
    push_frame(1'b0, 8, 4, 1);
    pulse_start_a();
    wait_idle_a(200);
    chk("post_rst_frame_cnt", {16'd0, a_frame}, 32'd1);
    chk("post_rst_done_cnt", a_done_cnt, 32'd6);

    // PPC=4 instance: x = 0,4,8,12 per line.
    push_frame(1'b1, 16, 2, 4);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    chk("b_latency_valid", {31'd0, b_valid}, 32'd1);
    repeat (20) @(negedge clk);
    chk("b_queue_empty", qb.size(), 32'd0);
    chk("b_frame_cnt", {16'd0, b_frame}, 32'd1);
    chk("b_done_cnt", b_done_cnt, 32'd1);
    chk("b_idle_valid", {31'd0, b_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/raster_coord_gen.md
RASTER_COORD_GEN -- requirements
Module: raster_coord_gen

Interface
REQ-001 Parameter WIDTH, default 1080: active pixels per line.
REQ-002 Parameter HEIGHT, default 960: active lines per frame.
REQ-003 Parameter PPC, default 1: pixels per beat; legal values 1, 2, 4; WIDTH % PPC == 0.
REQ-004 Parameter COORD_W, default 12: coordinate width; 2^COORD_W > max(WIDTH, HEIGHT).
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: one-cycle request to begin generation.
REQ-008 Port stop, input, 1: request to end generation at the next frame boundary.
REQ-009 Port mode_single, input, 1: 1 = one frame per start; 0 = continuous frames.
REQ-010 Port out_valid, output, 1: beat valid.
REQ-011 Port out_ready, input, 1: downstream (memory interface) accepts beat.
REQ-012 Port out_x, output, COORD_W: x of first pixel in beat.
REQ-013 Port out_y, output, COORD_W: line of beat.
REQ-014 Port out_sof / out_eol / out_eof, output, 1 each: first beat of frame / last beat of line / last beat of frame.
REQ-015 Port frame_cnt, output, 16: completed frames since reset, wraps at 65535 -> 0.
REQ-016 Port busy, output, 1: high in RUN.
REQ-017 Port done, output, 1: one-cycle pulse on leaving RUN.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE.
REQ-019 IDLE: out_valid=0; start=1 -> RUN, x=0, y=0; other inputs ignored.
REQ-020 Latency: start sampled high in cycle N -> out_valid=1 in cycle N+1 with out_x=0, out_y=0, out_sof=1.
REQ-021 RUN: out_valid=1 every cycle; a beat transfers only when out_valid && out_ready.
REQ-022 While out_valid && !out_ready, out_x, out_y and all flags SHALL hold stable.
REQ-023 On transfer, x SHALL advance by PPC; at x == WIDTH-PPC, x -> 0 and y increments.
REQ-024 out_eol = (x == WIDTH-PPC); out_eof = out_eol && (y == HEIGHT-1); out_sof = (x==0 && y==0); all combinational from current x,y, valid only when out_valid.
REQ-025 On the eof transfer, frame_cnt SHALL increment in the same edge.
REQ-026 On the eof transfer: if mode_single=1 or stop latched -> DONE; else y -> 0, x -> 0, remain RUN with no bubble.
REQ-027 stop SHALL be latched in a sticky flag while in RUN; flag cleared on entry to IDLE; stop in IDLE ignored.
REQ-028 stop coincident with the eof transfer SHALL end generation at that frame.
REQ-029 start while in RUN or DONE SHALL be ignored.
REQ-030 DONE: out_valid=0, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-031 mode_single SHALL be sampled only on the eof transfer.
REQ-032 Coordinate arithmetic SHALL be unsigned COORD_W; no value beyond WIDTH-PPC or HEIGHT-1 ever appears on out_x/out_y.
REQ-033 Illegal parameters (WIDTH % PPC != 0, PPC not 1/2/4, COORD_W too small) SHALL raise a simulation-time error at elaboration.

Reset
REQ-034 reset low SHALL immediately (asynchronously) force: state IDLE, out_valid=0, x=0, y=0, out_sof/eol/eof=0, frame_cnt=0, busy=0, done=0, stop flag cleared.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release, no beat until a new start.
REQ-036 Release SHALL be synchronised internally; first start honoured no earlier than the second rising edge after release.

Verification
REQ-037 WIDTH=8, HEIGHT=4, PPC=1, mode_single=1, out_ready=1, start pulse -> 32 beats; sof on beat 0; eol on beats 7,15,23,31; eof on beat 31; frame_cnt=1; done one cycle after beat 31; then IDLE.
REQ-038 Same config, out_ready random 50% -> identical beat sequence, payload stable during stalls, no beat dropped or duplicated.
REQ-039 WIDTH=16, HEIGHT=2, PPC=4 -> out_x sequence 0,4,8,12,0,4,8,12; eol on x=12.
REQ-040 mode_single=0, stop pulsed at beat 5 of frame 0 -> frame 0 completes, frame_cnt=1, done pulse, no further beats.
REQ-041 reset low at beat 10 of a frame -> out_valid=0 and frame_cnt=0 before next clock edge; start after release -> beat 0 at x=0, y=0.
REQ-042 start pulsed during RUN -> no restart; coordinate sequence unchanged.
